down_counter_sched: RTL
=======================

Name: down_counter_sched

Overview:
Round-robin scheduler that shares a single CW-bit down counter among N_REQ requesters needing countdown timeouts. It arbitrates pending requests and loads the winner's length into the shared counter. It then sequences the countdown and returns a per-requester done pulse. It sits between the timeout clients and the down-counter datapath; the counter is implemented inside this block and its value is exported.

Parameters:
N_REQ, 4, number of requesters (2..8)
CW, 3, counter width in bits; lengths 0..2^CW-1

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
req  input  N_REQ  per-requester request level; held until gnt
len  input  N_REQ*CW  packed lengths; requester i uses bits [i*CW +: CW]
pause  input  1  freeze countdown while high
abort  input  1  cancel active countdown
gnt  output  N_REQ  one-hot, 1-cycle pulse on acceptance
done  output  N_REQ  one-hot, 1-cycle pulse on expiry
aborted  output  1  1-cycle pulse when a countdown is cancelled
busy  output  1  high in COUNT and DONE
cur_id  output  3  index of the active/last-served requester
count  output  CW  current counter value

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. All outputs are registered.
- Reset: rst high forces state IDLE. gnt=0, done=0, aborted=0, busy=0, cur_id=0, count=0. The round-robin pointer is set to last=N_REQ-1, so requester 0 has first priority. Reset takes effect immediately, including mid-countdown; no done is issued.
- States: IDLE, COUNT, DONE.
- IDLE:
  - req is sampled only in IDLE.
  - If any req bit is high, the winner is the first set bit searching from last+1 upward, with wrap-around.
  - At the next edge: state->COUNT, count<=len[winner], cur_id<=winner, last<=winner, gnt[winner]=1 for that one cycle, busy=1.
  - If no req bit is high, the block stays in IDLE.
- COUNT:
  - abort=1: next state is IDLE, count<=0, busy=0, aborted=1 for one cycle, and no done is issued. abort has priority over pause.
  - Else pause=1: count and state hold.
  - Else count!=0: count decrements by 1.
  - Else count==0: next state is DONE, done[cur_id]=1 for one cycle.
- DONE: unconditionally goes to IDLE at the next edge, with busy=0.
- Latency: gnt cycle to done cycle is len+1 cycles (no pause). len=0 gives done 1 cycle after gnt. Grant of the next request comes no earlier than 2 cycles after done (DONE->IDLE, then the IDLE sample edge).
- Requesters:
  - A requester must hold req until its gnt cycle and drop it the cycle after.
  - A req dropped before grant is simply not served.
  - A req still high in IDLE after its own done is treated as a new request.
- abort in IDLE or DONE is ignored. pause outside COUNT is ignored.
- count never underflows; it wraps neither direction.
- len is sampled only at the grant edge; later changes have no effect.
- Simultaneous requests are resolved strictly by the round-robin order above. No requester waits more than N_REQ-1 other grants.

Test Plan:
1. Reset: rst pulsed asynchronously mid-cycle during COUNT with count=5 -> all outputs 0 immediately, no done; after release, req[2]=1 is granted first.
2. Single countdown: req[1]=1, len[1]=3, sampled at edge t -> gnt[1]=1 and count=3 at t+1; count=2,1,0 at t+2..t+4; done[1]=1 at t+5; busy=0 and state IDLE at t+6.
3. Zero length: req[0]=1, len=0 -> gnt[0] at t+1 with count=0, done[0] at t+2.
4. Round-robin: req=4'b1111 held, each requester dropping req after its gnt, all len=1 -> grant order 0,1,2,3. Then req=4'b1001 -> grant order 0,3,0.
5. Pause and abort: len=7 granted, pause high for 3 cycles at count=4 -> count holds at 4 for those 3 cycles, then resumes. abort and pause both high at count=2 -> aborted=1 next cycle, count=0, no done pulse.
6. Max length: len=7 (CW=3) -> count walks 7..0 with no wrap, and done arrives exactly 8 cycles after gnt.

Source files
------------

// File: rtl/down_counter_sched.sv
// ---------------------------------------------------------------------------
// down_counter_sched
//
// Round-robin scheduler sharing a single CW-bit down counter among N_REQ
// requesters. A pending request is granted in IDLE, the winner's length is
// loaded into the counter, the counter runs down to zero (freezable by
// pause, cancellable by abort), and a one-cycle done pulse is returned to
// the requester that owned the countdown.
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   req      per-requester request level, held until its gnt
//   len      packed lengths, requester i uses len[i*CW +: CW]
//   pause    freezes the countdown while high (COUNT only)
//   abort    cancels the active countdown (COUNT only, beats pause)
//   gnt      one-hot, one-cycle pulse on acceptance
//   done     one-hot, one-cycle pulse on expiry
//   aborted  one-cycle pulse when a countdown is cancelled
//   busy     high in COUNT and DONE
//   cur_id   index of the active / last-served requester
//   count    current counter value
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module down_counter_sched #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned CW    = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*CW-1:0] len,
    input  logic                pause,
    input  logic                abort,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    done,
    output logic                aborted,
    output logic                busy,
    output logic [2:0]          cur_id,
    output logic [CW-1:0]       count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state, nxt_state;
    logic [2:0]         last, nxt_last;
    // One-hot copy of the active requester, so done needs no index decode.
    logic [N_REQ-1:0]   cur_mask, nxt_mask;

    logic [N_REQ-1:0]   nxt_gnt, nxt_done;
    logic               nxt_aborted, nxt_busy;
    logic [2:0]         nxt_cur_id;
    logic [CW-1:0]      nxt_count;

    // Round-robin pick: first set req bit searching from last+1 with wrap.
    logic               found;
    int unsigned        win;

    always_comb begin
        found = 1'b0;
        win   = 0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            int unsigned idx;
            idx = (32'(last) + i) % N_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            last     <= 3'(N_REQ - 1);
            cur_mask <= '0;
            gnt      <= '0;
            done     <= '0;
            aborted  <= 1'b0;
            busy     <= 1'b0;
            cur_id   <= '0;
            count    <= '0;
        end else begin
            state    <= nxt_state;
            last     <= nxt_last;
            cur_mask <= nxt_mask;
            gnt      <= nxt_gnt;
            done     <= nxt_done;
            aborted  <= nxt_aborted;
            busy     <= nxt_busy;
            cur_id   <= nxt_cur_id;
            count    <= nxt_count;
        end
    end

    always_comb begin
        nxt_state   = state;
        nxt_last    = last;
        nxt_mask    = cur_mask;
        nxt_gnt     = '0;
        nxt_done    = '0;
        nxt_aborted = 1'b0;
        nxt_busy    = busy;
        nxt_cur_id  = cur_id;
        nxt_count   = count;

        unique case (state)
            IDLE: begin
                nxt_busy = 1'b0;
                if (found) begin
                    nxt_state  = COUNT;
                    nxt_count  = len[win*CW +: CW];
                    nxt_cur_id = 3'(win);
                    nxt_last   = 3'(win);
                    nxt_mask   = N_REQ'(1) << win;
                    nxt_gnt    = N_REQ'(1) << win;
                    nxt_busy   = 1'b1;
                end
            end

            COUNT: begin
                if (abort) begin
                    nxt_state   = IDLE;
                    nxt_count   = '0;
                    nxt_busy    = 1'b0;
                    nxt_aborted = 1'b1;
                end else if (pause) begin
                    nxt_count = count;
                end else if (count != '0) begin
                    nxt_count = count - 1'b1;
                end else begin
                    nxt_state = DONE;
                    nxt_done  = cur_mask;
                end
            end

            DONE: begin
                nxt_state = IDLE;
                nxt_busy  = 1'b0;
            end

            default: begin
                nxt_state = IDLE;
                nxt_busy  = 1'b0;
            end
        endcase
    end

endmodule
